// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the tick_gen divider and its channel slices.
package tick_gen_pkg;

  // Divide value that parks a channel: counter held at zero, no strobes.
  localparam int DIV_OFF = 0;

  // Channel-select width, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One divider channel: counter, live and pending divide values, strobe and optional square wave.
// Square-wave flop exists only when TICK_GEN_SQ_OUT_EN is defined; otherwise sq is tied low.
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int          CNT_W       = 27,
  parameter int unsigned DEFAULT_DIV = 2**18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             pend_o,
  output logic             tick,
  output logic             sq
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] pdiv_reg;
  logic             pend_reg;
  logic             tick_reg;
  logic             active;
  logic             wrap;

  assign active = en && (div_reg != CNT_W'(DIV_OFF));
  assign wrap   = active && (cnt_reg == div_reg - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      div_reg  <= CNT_W'(DEFAULT_DIV);
      pdiv_reg <= '0;
      pend_reg <= 1'b0;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= wrap;
      if (load) begin
        pend_reg <= 1'b1;
        pdiv_reg <= load_div;
      end
      if (wrap) begin
        cnt_reg <= '0;
      end else if (active) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end else if (div_reg == CNT_W'(DIV_OFF)) begin
        cnt_reg <= '0;
      end
      // A pending value lands on the wrap (old period's strobe still fires) or at once when idle.
      if (pend_reg && (wrap || !active)) begin
        div_reg  <= pdiv_reg;
        cnt_reg  <= '0;
        pend_reg <= 1'b0;
      end
    end
  end

  assign pend_o = pend_reg;
  assign tick   = tick_reg;

`ifdef TICK_GEN_SQ_OUT_EN
  logic sq_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_reg <= 1'b0;
    end else if (wrap) begin
      sq_reg <= ~sq_reg;
    end
  end

  assign sq = sq_reg;
`else
  assign sq = 1'b0;
`endif

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable tick divider with a per-channel one-deep config slot.
// Define TICK_GEN_SQ_OUT_EN to build the 50%-duty square-wave outputs.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 27,
  parameter int unsigned DEFAULT_DIV = 2**18,
  localparam int         CH_W        = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] load;

  // Out-of-range channel numbers are always ready and the write goes nowhere.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (32'(cfg_ch) == i) begin
        cfg_ready = !pend[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign load[gi] = cfg_valid && cfg_ready && (32'(cfg_ch) == gi);

      tick_gen_ch #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load[gi]),
        .load_div (cfg_div),
        .pend_o   (pend[gi]),
        .tick     (tick[gi]),
        .sq       (sq[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tick_gen.sv
// Table-driven bench for tick_gen: each row is one clock edge with inputs and expected strobes/ready.
module tb_tick_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_ready;
  logic [3:0] tick;
  logic [3:0] sq;

  // Second instance with a non-power-of-two channel count to reach an out-of-range cfg_ch.
  logic       cfg3_valid = 1'b0;
  logic [1:0] cfg3_ch = '0;
  logic [7:0] cfg3_div = '0;
  logic       cfg3_ready;
  logic [2:0] tick3;
  logic [2:0] sq3;

  tick_gen #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .tick(tick), .sq(sq)
  );

  tick_gen #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(4)) dut3 (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg3_valid), .cfg_ready(cfg3_ready),
    .cfg_ch(cfg3_ch), .cfg_div(cfg3_div), .tick(tick3), .sq(sq3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       valid;
    logic [1:0] ch;
    logic [7:0] div;
    logic [3:0] tick;
    logic       ready;
  } vec_t;

  vec_t       vecs [32];
  int         nvec = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] sq_model = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic build(input int n, input logic [1:0] ch);
    nvec = n;
    for (int i = 0; i < n; i++) begin
      vecs[i].en    = 1'b1;
      vecs[i].valid = 1'b0;
      vecs[i].ch    = ch;
      vecs[i].div   = '0;
      vecs[i].tick  = '0;
      vecs[i].ready = 1'b1;
    end
  endtask

  task automatic set_tick(input int k, input logic [3:0] t);
    vecs[k-1].tick = t;
  endtask

  task automatic set_write(input int k, input logic [7:0] d);
    vecs[k-1].valid = 1'b1;
    vecs[k-1].div   = d;
  endtask

  task automatic set_busy(input int k);
    vecs[k-1].ready = 1'b0;
  endtask

  task automatic run_table(input string phase);
    for (int i = 0; i < nvec; i++) begin
      en        = vecs[i].en;
      cfg_valid = vecs[i].valid;
      cfg_ch    = vecs[i].ch;
      cfg_div   = vecs[i].div;
      #1;
      chk($sformatf("%s edge%0d cfg_ready", phase, i + 1), 32'(cfg_ready), 32'(vecs[i].ready));
      @(posedge clk);
      #1;
`ifdef TICK_GEN_SQ_OUT_EN
      sq_model = sq_model ^ vecs[i].tick;
`endif
      chk($sformatf("%s edge%0d tick", phase, i + 1), 32'(tick), 32'(vecs[i].tick));
      chk($sformatf("%s edge%0d sq", phase, i + 1), 32'(sq), 32'(sq_model));
      $display("%s edge%0d en=%0b valid=%0b ch=%0d div=%0d tick=%b sq=%b ready=%0b",
               phase, i + 1, vecs[i].en, vecs[i].valid, vecs[i].ch, vecs[i].div, tick, sq, cfg_ready);
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset tick", 32'(tick), 32'h0);
    chk("reset sq", 32'(sq), 32'h0);
    chk("reset cfg_ready", 32'(cfg_ready), 32'h1);
    rst = 1'b0;

    // Default period 4, then ch1 reprogrammed to 6 at edge 5, applied at the edge-8 wrap.
    build(20, 2'd1);
    set_write(5, 8'd6);
    set_busy(6); set_busy(7); set_busy(8);
    set_tick(4, 4'hF); set_tick(8, 4'hF); set_tick(12, 4'hD);
    set_tick(14, 4'h2); set_tick(16, 4'hD); set_tick(20, 4'hF);
    run_table("div6");

    // ch2 disabled after its current period, then restarted with div=3.
    build(16, 2'd2);
    set_write(1, 8'd0);
    set_busy(2); set_busy(3); set_busy(4);
    set_write(9, 8'd3);
    set_busy(10);
    set_tick(4, 4'hD); set_tick(6, 4'h2); set_tick(8, 4'h9);
    set_tick(12, 4'hB); set_tick(13, 4'h4); set_tick(16, 4'hD);
    run_table("div0");

    // en low for ten edges mid-count: everything freezes, then resumes shifted by 10.
    build(19, 2'd0);
    for (int k = 3; k <= 12; k++) vecs[k-1].en = 1'b0;
    set_tick(2, 4'h2); set_tick(13, 4'h4); set_tick(14, 4'h9);
    set_tick(16, 4'h4); set_tick(18, 4'hB); set_tick(19, 4'h4);
    run_table("engap");

    // ch0 set to div=1: strobe on every edge once applied.
    build(8, 2'd0);
    set_write(1, 8'd1);
    set_busy(2); set_busy(3);
    set_tick(3, 4'hD); set_tick(4, 4'h1); set_tick(5, 4'h3);
    set_tick(6, 4'h5); set_tick(7, 4'h9); set_tick(8, 4'h1);
    run_table("div1");

    // Reset while ch1 holds a pending write: outputs clear at once, the write is dropped.
    build(1, 2'd1);
    set_write(1, 8'd5);
    set_tick(1, 4'h5);
    run_table("prerst");
    #1;
    chk("ch1 pending before rst", 32'(cfg_ready), 32'h0);
    #1 rst = 1'b1;
    #1;
    chk("rst async tick", 32'(tick), 32'h0);
    chk("rst async sq", 32'(sq), 32'h0);
    chk("rst async cfg_ready", 32'(cfg_ready), 32'h1);
    sq_model = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    build(12, 2'd1);
    set_tick(4, 4'hF); set_tick(8, 4'hF); set_tick(12, 4'hF);
    run_table("postrst");
    chk("dut3 tick", 32'(tick3), 32'h7);
    chk("dut3 sq", 32'(sq3), 32'(sq_model[2:0]));

    // Out-of-range channel: always ready and no channel takes the value.
    cfg3_ch    = 2'd3;
    cfg3_div   = 8'd1;
    cfg3_valid = 1'b1;
    #1;
    chk("oor cfg_ready", 32'(cfg3_ready), 32'h1);
    @(posedge clk);
    #1 cfg3_valid = 1'b0;
    $display("oor write ch=3 div=1 ready=%0b", cfg3_ready);
    for (int c = 0; c < 3; c++) begin
      cfg3_ch = 2'(c);
      #1;
      chk($sformatf("oor ch%0d untouched", c), 32'(cfg3_ready), 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
